mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Serialises the core's instruction-fetch port and load/store port onto a
// single shared memory interface with exactly one transaction in flight.
// Both ports are captured together when either requests. The priority port
// (A) is served first, then the other port (B). The core is frozen through
// stallreq until the last response has been latched.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   inst_sram_en/wen/addr/wdata -> inst_sram_rdata   fetch port
//   data_sram_en/wen/addr/wdata -> data_sram_rdata   load/store port
//   stallreq                 freeze request to the pipeline controller
//   mem_req/wr/wstrb/addr/wdata                      shared request channel
//   mem_addr_ok              request accepted this cycle
//   mem_data_ok, mem_rdata   response valid and read data
//
// DATA_FIRST = 1 makes the data port the priority port; 0 makes the
// instruction port the priority port.
module mem_port_arbiter #(
  parameter int DATA_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B, DONE} state_t;

  localparam logic A_IS_DATA = (DATA_FIRST != 0);

  state_t      state_q, state_d;
  logic        a_en_q, a_en_d, b_en_q, b_en_d;
  logic [3:0]  a_wen_q, a_wen_d, b_wen_q, b_wen_d;
  logic [31:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [31:0] a_wdata_q, a_wdata_d, b_wdata_q, b_wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;

  // Core ports remapped onto priority slots A and B.
  logic        in_a_en, in_b_en;
  logic [3:0]  in_a_wen, in_b_wen;
  logic [31:0] in_a_addr, in_b_addr, in_a_wdata, in_b_wdata;
  logic        any_en;
  logic        sel_b;

  assign in_a_en    = A_IS_DATA ? data_sram_en    : inst_sram_en;
  assign in_a_wen   = A_IS_DATA ? data_sram_wen   : inst_sram_wen;
  assign in_a_addr  = A_IS_DATA ? data_sram_addr  : inst_sram_addr;
  assign in_a_wdata = A_IS_DATA ? data_sram_wdata : inst_sram_wdata;
  assign in_b_en    = A_IS_DATA ? inst_sram_en    : data_sram_en;
  assign in_b_wen   = A_IS_DATA ? inst_sram_wen   : data_sram_wen;
  assign in_b_addr  = A_IS_DATA ? inst_sram_addr  : data_sram_addr;
  assign in_b_wdata = A_IS_DATA ? inst_sram_wdata : data_sram_wdata;
  assign any_en     = inst_sram_en | data_sram_en;

  // The request channel shows slot B only while B is being served; in every
  // other state it shows slot A, which matters only while mem_req is high.
  assign sel_b     = (state_q == REQ_B) || (state_q == WAIT_B);
  assign mem_wr    = sel_b ? (|b_wen_q) : (|a_wen_q);
  assign mem_wstrb = sel_b ? b_wen_q   : a_wen_q;
  assign mem_addr  = sel_b ? b_addr_q  : a_addr_q;
  assign mem_wdata = sel_b ? b_wdata_q : a_wdata_q;

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

  always_comb begin
    state_d      = state_q;
    a_en_d       = a_en_q;
    a_wen_d      = a_wen_q;
    a_addr_d     = a_addr_q;
    a_wdata_d    = a_wdata_q;
    b_en_d       = b_en_q;
    b_wen_d      = b_wen_q;
    b_addr_d     = b_addr_q;
    b_wdata_d    = b_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    stallreq     = 1'b0;
    mem_req      = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_en) begin
          stallreq  = 1'b1;
          a_en_d    = in_a_en;
          a_wen_d   = in_a_wen;
          a_addr_d  = in_a_addr;
          a_wdata_d = in_a_wdata;
          b_en_d    = in_b_en;
          b_wen_d   = in_b_wen;
          b_addr_d  = in_b_addr;
          b_wdata_d = in_b_wdata;
          state_d   = in_a_en ? REQ_A : REQ_B;
        end
      end
      REQ_A: begin
        stallreq = 1'b1;
        mem_req  = 1'b1;
        if (mem_addr_ok) state_d = WAIT_A;
      end
      // A response coinciding with mem_addr_ok is seen in REQ and dropped;
      // only responses arriving in a WAIT state are taken.
      WAIT_A: begin
        stallreq = 1'b1;
        if (mem_data_ok) begin
          if (a_wen_q == 4'b0000) begin
            if (A_IS_DATA) data_rdata_d = mem_rdata;
            else           inst_rdata_d = mem_rdata;
          end
          state_d = b_en_q ? REQ_B : DONE;
        end
      end
      REQ_B: begin
        stallreq = 1'b1;
        mem_req  = 1'b1;
        if (mem_addr_ok) state_d = WAIT_B;
      end
      WAIT_B: begin
        stallreq = 1'b1;
        if (mem_data_ok) begin
          if (b_wen_q == 4'b0000) begin
            if (A_IS_DATA) inst_rdata_d = mem_rdata;
            else           data_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end
      end
      // One cycle with the stall released so the core can advance; the core
      // inputs still show the request just served and must not be captured.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!rst) stallreq = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      a_en_q       <= 1'b0;
      a_wen_q      <= 4'b0000;
      a_addr_q     <= 32'h0;
      a_wdata_q    <= 32'h0;
      b_en_q       <= 1'b0;
      b_wen_q      <= 4'b0000;
      b_addr_q     <= 32'h0;
      b_wdata_q    <= 32'h0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      a_en_q       <= a_en_d;
      a_wen_q      <= a_wen_d;
      a_addr_q     <= a_addr_d;
      a_wdata_q    <= a_wdata_d;
      b_en_q       <= b_en_d;
      b_wen_q      <= b_wen_d;
      b_addr_q     <= b_addr_d;
      b_wdata_q    <= b_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives core-side requests, models the shared memory and checks every
// request issued on the memory channel against a queue of expected requests
// built when the core-side stimulus is applied. Stall length and the rdata
// registers are checked in the cycle where the stall drops.
module tb_mem_port_arbiter;

  localparam int DATA_FIRST_TB = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        stallreq;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  mem_port_arbiter #(.DATA_FIRST(DATA_FIRST_TB)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .stallreq(stallreq),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [68:0] req;    // {wr, wstrb, addr, wdata}
    logic [31:0] rdata;  // value the memory returns for this request
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_irdata = 32'h0;
  logic [31:0] exp_drdata = 32'h0;

  // memory model controls
  int          addr_delay = 0;
  int          data_gap   = 0;
  bit          spurious   = 1'b0;
  int          hold_at    = 0;   // nonzero: never answer accept number >= hold_at
  int          acc_cnt    = 0;
  int          dly_cnt    = 0;
  int          gap_cnt    = 0;
  bit          resp_armed = 1'b0;
  logic [31:0] resp_val   = 32'h0;
  exp_t        cur;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Shared memory: checks each presented request against the queue head,
  // accepts after addr_delay cycles, answers data_gap cycles into WAIT.
  always @(negedge clk) begin
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    if (resp_armed) begin
      if (!(hold_at != 0 && acc_cnt >= hold_at)) begin
        if (gap_cnt >= data_gap) begin
          mem_data_ok = 1'b1;
          mem_rdata   = resp_val;
          resp_armed  = 1'b0;
        end else begin
          gap_cnt++;
        end
      end
    end else if (mem_req) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_mem_req", {95'h0, mem_req}, 96'h0);
      end else begin
        cur = exp_q[0];
        check_eq("mem_req_fields", {27'h0, mem_wr, mem_wstrb, mem_addr, mem_wdata},
                 {27'h0, cur.req});
        if (dly_cnt >= addr_delay) begin
          mem_addr_ok = 1'b1;
          void'(exp_q.pop_front());
          resp_armed = 1'b1;
          resp_val   = cur.rdata;
          gap_cnt    = 0;
          dly_cnt    = 0;
          acc_cnt++;
          if (spurious) begin
            mem_data_ok = 1'b1;
            mem_rdata   = 32'hDEAD_BEEF;
          end
        end else begin
          dly_cnt++;
        end
      end
    end
  end

  task automatic drive_ports(input logic ien, input logic [3:0] iwen, input logic [31:0] iaddr,
                             input logic [31:0] iwdata, input logic den, input logic [3:0] dwen,
                             input logic [31:0] daddr, input logic [31:0] dwdata);
    inst_sram_en = ien;  inst_sram_wen = iwen;  inst_sram_addr = iaddr;  inst_sram_wdata = iwdata;
    data_sram_en = den;  data_sram_wen = dwen;  data_sram_addr = daddr;  data_sram_wdata = dwdata;
  endtask

  task automatic push_expected(input logic ien, input logic [3:0] iwen, input logic [31:0] iaddr,
                               input logic [31:0] iwdata, input logic den, input logic [3:0] dwen,
                               input logic [31:0] daddr, input logic [31:0] dwdata,
                               input logic [31:0] i_ret, input logic [31:0] d_ret);
    exp_t ei, ed;
    ei.req = {|iwen, iwen, iaddr, iwdata};  ei.rdata = i_ret;
    ed.req = {|dwen, dwen, daddr, dwdata};  ed.rdata = d_ret;
    if (DATA_FIRST_TB != 0) begin
      if (den) exp_q.push_back(ed);
      if (ien) exp_q.push_back(ei);
    end else begin
      if (ien) exp_q.push_back(ei);
      if (den) exp_q.push_back(ed);
    end
    if (ien && iwen == 4'b0000) exp_irdata = i_ret;
    if (den && dwen == 4'b0000) exp_drdata = d_ret;
  endtask

  // One core request (one or both ports), applied right after a clock edge
  // and held until the stall drops.
  task automatic run_txn(input string name,
                         input logic ien, input logic [3:0] iwen, input logic [31:0] iaddr,
                         input logic [31:0] iwdata, input logic den, input logic [3:0] dwen,
                         input logic [31:0] daddr, input logic [31:0] dwdata,
                         input logic [31:0] i_ret, input logic [31:0] d_ret,
                         input int adly, input int dgap, input bit spur);
    int nports, stall, exp_stall;
    @(posedge clk); #1;
    addr_delay = adly;  data_gap = dgap;  spurious = spur;  dly_cnt = 0;
    drive_ports(ien, iwen, iaddr, iwdata, den, dwen, daddr, dwdata);
    push_expected(ien, iwen, iaddr, iwdata, den, dwen, daddr, dwdata, i_ret, d_ret);
    nports    = int'(ien) + int'(den);
    exp_stall = (nports == 0) ? 0 : 1 + nports * (adly + 2 + dgap);
    stall = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (stallreq) stall++;
      else break;
    end
    check_eq({name, ":stall_cycles"}, 96'(stall), 96'(exp_stall));
    check_eq({name, ":inst_rdata"}, {64'h0, inst_sram_rdata}, {64'h0, exp_irdata});
    check_eq({name, ":data_rdata"}, {64'h0, data_sram_rdata}, {64'h0, exp_drdata});
    check_eq({name, ":requests_left"}, 96'(exp_q.size()), 96'h0);
    exp_q.delete();
    $display("[TB] txn %-12s inst(en=%0d wen=%b a=%h) data(en=%0d wen=%b a=%h) stall=%0d irdata=%h drdata=%h",
             name, ien, iwen, iaddr, den, dwen, daddr, stall, inst_sram_rdata, data_sram_rdata);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_ports(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check_eq("idle_stall", {95'h0, stallreq}, 96'h0);
      check_eq("idle_mem_req", {95'h0, mem_req}, 96'h0);
    end
  endtask

  // Both ports read; the second response is withheld so the block sits in
  // WAIT_B when reset hits. The withheld response is released afterwards.
  task automatic reset_in_wait_b();
    @(posedge clk); #1;
    addr_delay = 0;  data_gap = 0;  spurious = 1'b0;  dly_cnt = 0;
    acc_cnt = 0;  hold_at = 2;
    drive_ports(1'b1, 4'h0, 32'h0000_0300, 32'h0, 1'b1, 4'h0, 32'h8000_0300, 32'h0);
    push_expected(1'b1, 4'h0, 32'h0000_0300, 32'h0, 1'b1, 4'h0, 32'h8000_0300, 32'h0,
                  32'h7777_7777, 32'h6666_6666);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (acc_cnt >= 2) break;
    end
    @(negedge clk);
    check_eq("rst_mid:acc_count", 96'(acc_cnt), 96'd2);
    check_eq("rst_mid:stall_in_wait_b", {95'h0, stallreq}, 96'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_ports(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check_eq("rst_mid:stall_during_rst", {95'h0, stallreq}, 96'h0);
    @(negedge clk);
    exp_irdata = 32'h0;  exp_drdata = 32'h0;
    check_eq("rst_mid:stall_after", {95'h0, stallreq}, 96'h0);
    check_eq("rst_mid:mem_req", {95'h0, mem_req}, 96'h0);
    check_eq("rst_mid:inst_rdata", {64'h0, inst_sram_rdata}, {64'h0, exp_irdata});
    check_eq("rst_mid:data_rdata", {64'h0, data_sram_rdata}, {64'h0, exp_drdata});
    @(posedge clk); #1;
    rst = 1'b1;
    hold_at = 0;   // the late response goes out at the next negedge
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_late:resp_sent", {95'h0, resp_armed}, 96'h0);
    check_eq("rst_late:inst_rdata", {64'h0, inst_sram_rdata}, {64'h0, exp_irdata});
    check_eq("rst_late:data_rdata", {64'h0, data_sram_rdata}, {64'h0, exp_drdata});
    check_eq("rst_late:stall", {95'h0, stallreq}, 96'h0);
    exp_q.delete();
    $display("[TB] txn %-12s reset in WAIT_B, late response ignored, irdata=%h drdata=%h",
             "rst_wait_b", inst_sram_rdata, data_sram_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    // Request held high during reset: stall must still stay low.
    drive_ports(1'b1, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset:stallreq", {95'h0, stallreq}, 96'h0);
    check_eq("reset:mem_req", {95'h0, mem_req}, 96'h0);
    check_eq("reset:inst_rdata", {64'h0, inst_sram_rdata}, 96'h0);
    check_eq("reset:data_rdata", {64'h0, data_sram_rdata}, 96'h0);
    @(posedge clk); #1;
    drive_ports(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    rst = 1'b1;
    idle_cycles(2);

    run_txn("inst_min", 1'b1, 4'h0, 32'h0000_1000, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0,
            32'hA5A5_0001, 32'h0, 0, 0, 1'b0);
    idle_cycles(1);
    run_txn("inst_boot", 1'b1, 4'h0, 32'hBFC0_0000, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0,
            32'h3C1D_0001, 32'h0, 2, 0, 1'b0);
    idle_cycles(1);
    run_txn("both_reads", 1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b1, 4'h0, 32'h8000_0040, 32'h0,
            32'h1111_1111, 32'h2222_2222, 1, 1, 1'b0);
    run_txn("store_inst", 1'b1, 4'h0, 32'h0000_0104, 32'h0, 1'b1, 4'b0011, 32'h8000_0080,
            32'h1234_5678, 32'h3333_3333, 32'h0, 0, 0, 1'b0);
    run_txn("spurious", 1'b1, 4'h0, 32'h0000_0108, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0,
            32'h4444_4444, 32'h0, 0, 2, 1'b1);
    // back-to-back with identical held inputs: the second must be a fresh capture
    run_txn("b2b_1", 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h8000_0200, 32'h0,
            32'h0, 32'h5555_5555, 0, 0, 1'b0);
    run_txn("b2b_2", 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h8000_0200, 32'h0,
            32'h0, 32'h5A5A_5A5A, 0, 0, 1'b0);
    run_txn("data_wr", 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b1000, 32'h8000_0204,
            32'hCAFE_F00D, 32'h0, 32'h0, 1, 0, 1'b0);
    idle_cycles(2);
    reset_in_wait_b();
    run_txn("post_rst", 1'b1, 4'h0, 32'h0000_0400, 32'h0, 1'b1, 4'h0, 32'h8000_0400, 32'h0,
            32'h9999_0001, 32'h9999_0002, 0, 0, 1'b0);
    idle_cycles(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
